// File: rtl/frame_sync_controller.sv
// Frame sync controller: on each copy-window open, pulses GPU reset, runs a
// multi-client copy, then resumes the CPU and counts the completed frame.
module frame_sync_controller #(
  parameter int          VPOS_W    = 10,
  parameter int unsigned COPY_LINE = 511,
  parameter int          N_CH      = 2,
  parameter int          FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VPOS_W-1:0] vpos,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH-1:0]   ch_done,
  output logic              gpu_reset,
  output logic              copy_start,
  output logic              copy,
  output logic              resume,
  output logic              overrun,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [2:0] S_RUN      = 3'd0;
  localparam logic [2:0] S_GRST     = 3'd1;
  localparam logic [2:0] S_START    = 3'd2;
  localparam logic [2:0] S_COPY     = 3'd3;
  localparam logic [2:0] S_WAIT_END = 3'd4;
  localparam logic [2:0] S_RESUME   = 3'd5;

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic            copy_time;
  logic            ct_q;
  logic            win_open;
  logic [N_CH-1:0] done_mask;
  logic [N_CH-1:0] mask_nx;
  logic            mask_full;

  assign copy_time = 32'(vpos) >= COPY_LINE;
  assign win_open  = copy_time & ~ct_q;

  // Current-cycle completions count toward the exit decision.
  assign mask_nx   = done_mask | ch_done;
  assign mask_full = &mask_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RUN: begin
        if (win_open) state_nx = S_GRST;
      end
      S_GRST:  state_nx = S_START;
      S_START: state_nx = S_COPY;
      S_COPY: begin
        if (mask_full)
          state_nx = copy_time ? S_WAIT_END : S_RESUME;
      end
      S_WAIT_END: begin
        if (!copy_time) state_nx = S_RESUME;
      end
      S_RESUME: state_nx = S_RUN;
      default:  state_nx = S_RUN;
    endcase
  end

  // ct_q resets high so a reset inside the window waits for the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
      ct_q  <= 1'b1;
    end else begin
      state <= state_nx;
      ct_q  <= copy_time;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_mask <= '0;
    end else if (state == S_START) begin
      done_mask <= ~ch_en;
    end else if (state == S_COPY) begin
      done_mask <= mask_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (state == S_GRST) begin
      overrun <= 1'b0;
    end else if (state == S_COPY && !mask_full && !copy_time) begin
      overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (state == S_RESUME) begin
      frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

  assign gpu_reset  = (state == S_GRST);
  assign copy_start = (state == S_START);
  assign copy       = (state == S_START) |
                      (state == S_COPY)  |
                      (state == S_WAIT_END);
  assign resume     = (state == S_RESUME);

endmodule

// File: tb/tb_frame_sync_controller.sv
// Bench for frame_sync_controller: directed frames plus random frames
// checked against a cycle-by-cycle behavioural model.
module tb_frame_sync_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] vpos;
  logic [1:0] ch_en;
  logic [1:0] ch_done;

  logic        gpu_reset, copy_start, copy, resume, overrun;
  logic [15:0] frame_cnt;
  logic        gpu_reset2, copy_start2, copy2, resume2, overrun2;
  logic [1:0]  frame_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_age;
  bit          m_res, m_ovr, m_all, m_ctp;
  logic [1:0]  m_owed;
  int unsigned m_frames;

  always #5 clk = ~clk;

  frame_sync_controller u_dut (
    .clk(clk), .reset(reset), .vpos(vpos),
    .ch_en(ch_en), .ch_done(ch_done),
    .gpu_reset(gpu_reset), .copy_start(copy_start),
    .copy(copy), .resume(resume),
    .overrun(overrun), .frame_cnt(frame_cnt)
  );

  frame_sync_controller #(.FCNT_W(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .vpos(vpos),
    .ch_en(ch_en), .ch_done(ch_done),
    .gpu_reset(gpu_reset2), .copy_start(copy_start2),
    .copy(copy2), .resume(resume2),
    .overrun(overrun2), .frame_cnt(frame_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_age = -1; m_res = 0; m_ovr = 0; m_all = 0;
    m_owed = '0; m_frames = 0; m_ctp = 1;
  endtask

  // Model: m_age counts cycles since the window opened (-1 when idle).
  task automatic m_step();
    bit ct;
    ct = (vpos >= 10'd511);
    if (m_res) begin
      m_res = 0; m_age = -1; m_frames++;
    end else if (m_age < 0) begin
      if (ct && !m_ctp) m_age = 1;
    end else if (m_age == 1) begin
      m_age = 2; m_ovr = 0;
    end else if (m_age == 2) begin
      m_age = 3; m_owed = ch_en; m_all = 0;
    end else begin
      m_age++;
      if (!m_all) begin
        m_owed = m_owed & ~ch_done;
        if (m_owed == 0) begin
          m_all = 1; m_res = !ct;
        end else if (!ct) begin
          m_ovr = 1;
        end
      end else if (!ct) begin
        m_res = 1;
      end
    end
    m_ctp = ct;
  endtask

  task automatic check_all();
    chk("gpu_reset", gpu_reset, m_age == 1 && !m_res);
    chk("copy_start", copy_start, m_age == 2);
    chk("copy", copy, m_age >= 2 && !m_res);
    chk("resume", resume, m_res);
    chk("overrun", overrun, m_ovr);
    chk("frame_cnt", frame_cnt, m_frames % 65536);
    chk("copy_w2", copy2, m_age >= 2 && !m_res);
    chk("frame_cnt_w2", frame_cnt2, m_frames % 4);
  endtask

  task automatic cyc(input logic [9:0] v, input logic [1:0] d,
                     input logic [1:0] e);
    vpos = v; ch_done = d; ch_en = e;
    @(posedge clk);
    m_step();
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    m_reset();
    chk("abort_copy", copy, 0);
    chk("abort_resume", resume, 0);
    chk("abort_fcnt", frame_cnt, 0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  task automatic run_frame(input int win, input int slow, input int abort_at);
    int c = 0;
    bit aborted = 0;
    logic [9:0] v;
    logic [1:0] d;
    while (1) begin
      v = (505 + c < 511 + win) ? 10'(505 + c) : 10'd0;
      d = 2'($urandom & $urandom);
      if (c < slow) d[1] = 1'b0;
      cyc(v, d, 2'($urandom));
      if (abort_at > 0 && !aborted && m_age == abort_at && !m_res) begin
        aborted = 1;
        mid_reset();
      end
      c++;
      if (c > 6 + win && m_age < 0 && !m_res) break;
      if (c > 400) begin
        chk("frame_timeout", c, 0);
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; vpos = '0; ch_en = '0; ch_done = '0;
    m_reset();
    #3;
    chk("rst_gpu", gpu_reset, 0);
    chk("rst_copy", copy, 0);
    check_all();
    @(posedge clk);
    #1 reset = 1'b0;

    // Both clients finish inside the window.
    cyc(10'd510, 2'b00, 2'b11);
    for (int k = 0; k < 26; k++) begin
      cyc(k < 20 ? 10'd511 : 10'd0, {k == 5, k == 3}, 2'b11);
      if (k == 0) chk("req035_gpu", gpu_reset, 1);
      if (k == 1) chk("req035_start", copy_start, 1);
      if (k == 19) chk("req035_copy", copy, 1);
      if (k == 20) chk("req035_resume", resume, 1);
    end
    chk("req035_fcnt", frame_cnt, 1);
    chk("req035_ovr", overrun, 0);

    // Client 1 finishes five lines after the window closes.
    cyc(10'd510, 2'b00, 2'b11);
    for (int k = 0; k < 30; k++) begin
      cyc(k < 20 ? 10'd511 : 10'd0, {k == 25, k == 3}, 2'b11);
      if (k == 24) chk("req036_ovr", overrun, 1);
      if (k == 24) chk("req036_hold", copy, 1);
      if (k == 25) chk("req036_resume", resume, 1);
    end
    chk("req036_fcnt", frame_cnt, 2);

    // No clients enabled: straight through copy.
    cyc(10'd510, 2'b00, 2'b00);
    for (int k = 0; k < 12; k++) begin
      cyc(k < 8 ? 10'd511 : 10'd0, 2'b00, 2'b00);
      if (k == 1) chk("req036_ovr_clr", overrun, 0);
      if (k == 3) chk("req037_wait", copy, 1);
      if (k == 8) chk("req037_resume", resume, 1);
    end

    // Release reset inside the window.
    #2 reset = 1'b1;
    vpos = 10'd520;
    m_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) cyc(10'd520, 2'b11, 2'b11);
    chk("req038_gpu", gpu_reset, 0);
    cyc(10'd100, 2'b00, 2'b11);
    cyc(10'd511, 2'b00, 2'b11);
    chk("req038_gpu_next", gpu_reset, 1);
    for (int k = 0; k < 6; k++) cyc(10'd0, 2'b11, 2'b11);

    for (int f = 0; f < 40; f++)
      run_frame($urandom_range(2, 25), $urandom_range(0, 36),
                f == 20 ? 4 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
